rv_muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Accepts one operation at a time over a valid/ready handshake, computes one bit per cycle, and returns a result tagged with the destination register.
- Generalises the ALU op set to all eight M-extension ops.
- Operand width is parametrised.

---
 rtl/rv_muldiv_unit_if.sv | 29 ++
 rtl/rv_muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_rv_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_unit_if.sv
// rv_muldiv_unit_if: request/response bundle for the iterative RV32M unit.
//   Request  : in_valid/in_ready handshake carrying op, rs1, rs2 and tag_in.
//   Response : out_valid/out_ready handshake carrying result and tag_out.
//   master modport = requester (execute stage), slave modport = the unit.
interface rv_muldiv_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            op;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;
  logic [TAG_WIDTH-1:0]  tag_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic [TAG_WIDTH-1:0]  tag_out;

  modport master (
    output in_valid, op, rs1, rs2, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out
  );

  modport slave (
    input  in_valid, op, rs1, rs2, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out
  );
endinterface

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide unit, one bit per clock.
//   clk   : clock
//   rst   : asynchronous active-high reset
//   flush : synchronous abort back to IDLE (in_valid ignored that cycle)
//   bus   : slave side of rv_muldiv_unit_if (request/response handshakes)
//   busy  : high whenever the unit is not IDLE
// Operands are converted to magnitudes at accept, the magnitude product or
// quotient/remainder is built over W CALC cycles, and the sign is applied in
// FIX. Divide-by-zero and signed overflow bypass CALC and go straight to DONE.
module rv_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  rv_muldiv_unit_if.slave      bus,
  output logic                 busy
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t               state, state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [2:0]           op_q;
  logic                 neg_q;
  logic [W-1:0]         result_q;
  logic [TAG_WIDTH-1:0] tag_q;
  // hi:lo is the 2W product (multiply) or remainder:quotient (divide);
  // m holds the multiplicand or divisor magnitude.
  logic [W-1:0]         hi_q, lo_q, m_q;

  function automatic logic [W-1:0] abs_val(input logic signed [W-1:0] v);
    return (v < 0) ? W'(-v) : W'(v);
  endfunction

  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic en);
    return en ? (~v + W'(1)) : v;
  endfunction

  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic en);
    return en ? (~v + (2*W)'(1)) : v;
  endfunction

  logic           accept;
  logic           is_div, signed_a, signed_b, neg_in;
  logic           div_zero, div_ovf, special;
  logic [W-1:0]   a_mag, b_mag, spec_res;

  assign accept = bus.in_valid && (state == IDLE) && !flush;

  always_comb begin
    is_div   = bus.op[2];
    // Unsigned ops (MULHU, DIVU, REMU) are exactly the odd funct3 codes >= 3.
    signed_a = !(bus.op == 3'd3 || bus.op == 3'd5 || bus.op == 3'd7);
    signed_b = (bus.op == OP_MUL) || (bus.op == OP_MULH) ||
               (bus.op == OP_DIV) || (bus.op == OP_REM);
    a_mag    = signed_a ? abs_val(bus.rs1) : bus.rs1;
    b_mag    = signed_b ? abs_val(bus.rs2) : bus.rs2;
    case (bus.op)
      OP_MUL, OP_MULH, OP_DIV: neg_in = bus.rs1[W-1] ^ bus.rs2[W-1];
      OP_MULHSU, OP_REM:       neg_in = bus.rs1[W-1];
      default:                 neg_in = 1'b0;
    endcase
    div_zero = is_div && (bus.rs2 == '0);
    div_ovf  = is_div && !bus.op[0] && (bus.rs1 == {1'b1, {(W-1){1'b0}}}) &&
               (bus.rs2 == '1);
    special  = div_zero || div_ovf;
    // op[1] separates REM/REMU from DIV/DIVU.
    if (div_zero) spec_res = bus.op[1] ? bus.rs1 : '1;
    else          spec_res = bus.op[1] ? '0 : bus.rs1;
  end

  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   div_sel, fix_res;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    div_shift = {hi_q, lo_q[W-1]};
    div_diff  = div_shift - {1'b0, m_q};
    // Negate the full product so the borrow reaches the high half correctly.
    prod_fix  = neg_2w({hi_q, lo_q}, neg_q);
    div_sel   = op_q[1] ? hi_q : lo_q;
    if (op_q[2])              fix_res = neg_w(div_sel, neg_q);
    else if (op_q == OP_MUL)  fix_res = prod_fix[W-1:0];
    else                      fix_res = prod_fix[2*W-1:W];
  end

  // ---- control: state register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (accept) state_nx = special ? DONE : CALC;
        CALC: if (cnt == CNT_W'(1)) state_nx = FIX;
        FIX:  state_nx = DONE;
        DONE: if (bus.out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---- control: counter, captured op/sign/tag, presented result ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt      <= '0;
    end else if (accept) begin
      cnt      <= CNT_W'(W);
      op_q     <= bus.op;
      neg_q    <= neg_in;
      tag_q    <= bus.tag_in;
      if (special) result_q <= spec_res;
    end else if (state == CALC) begin
      cnt      <= cnt - CNT_W'(1);
    end else if (state == FIX) begin
      result_q <= fix_res;
    end
  end

  // ---- datapath: shift-add / restoring shift-subtract iteration ----
  always_ff @(posedge clk) begin
    if (accept) begin
      hi_q <= '0;
      lo_q <= is_div ? a_mag : b_mag;
      m_q  <= is_div ? b_mag : a_mag;
    end else if (state == CALC) begin
      if (op_q[2]) begin
        hi_q <= div_diff[W] ? div_shift[W-1:0] : div_diff[W-1:0];
        lo_q <= {lo_q[W-2:0], ~div_diff[W]};
      end else begin
        hi_q <= mul_sum[W:1];
        lo_q <= {mul_sum[0], lo_q[W-1:1]};
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.tag_out   = tag_q;
  assign busy          = (state != IDLE);
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// tb_rv_muldiv_unit: self-checking bench for rv_muldiv_unit (W=32).
// Directed vector table, randomized ops against an arithmetic reference
// model, and hand-written backpressure / flush / async-reset sequences.
module tb_rv_muldiv_unit;
  localparam int W = 32;
  localparam int NORMAL_LAT = W + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;

  rv_muldiv_unit_if #(.DATA_WIDTH(W), .TAG_WIDTH(5)) bus ();

  rv_muldiv_unit #(.DATA_WIDTH(W), .TAG_WIDTH(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] t;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    t = '0;
    case (op)
      3'd0: begin t = sa * sb; return t[31:0]; end
      3'd1: begin t = sa * sb; return t[63:32]; end
      3'd2: begin t = sa * ub; return t[63:32]; end
      3'd3: begin t = ua * ub; return t[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        t = sa / sb; return t[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        t = sa % sb; return t[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Edges after the accept edge until out_valid is seen: special cases raise
  // out_valid on the accept edge itself (0), normal ops W+1 edges later.
  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 0;
    return NORMAL_LAT;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Called at posedge+1 with the unit idle; returns at posedge+1 with
  // out_valid high (or after the cycle budget expires).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] res, output logic [4:0] tg,
                        output int lat);
    bus.op = op; bus.rs1 = a; bus.rs2 = b; bus.tag_in = tag; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op = 3'($urandom); bus.rs1 = $urandom; bus.rs2 = $urandom; bus.tag_in = 5'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) chk("timeout_out_valid", 32'(bus.out_valid), 32'd1);
    res = bus.result;
    tg = bus.tag_out;
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after_release", 32'(bus.in_ready), 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[15];

  initial begin
    logic [31:0] res, r0;
    logic [4:0]  tg, t0;
    int lat, bad;

    vt[0]  = '{3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vt[1]  = '{3'd1, 32'h80000000,   32'h80000000, 32'h40000000, 33};
    vt[2]  = '{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vt[3]  = '{3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vt[4]  = '{3'd4, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 33};
    vt[5]  = '{3'd6, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, 33};
    vt[6]  = '{3'd5, 32'hFFFFFFFE,   32'd2,        32'h7FFFFFFF, 33};
    vt[7]  = '{3'd7, 32'd7,          32'd3,        32'd1,        33};
    vt[8]  = '{3'd4, 32'd5,          32'd0,        32'hFFFFFFFF, 0};
    vt[9]  = '{3'd7, 32'd5,          32'd0,        32'd5,        0};
    vt[10] = '{3'd4, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 0};
    vt[11] = '{3'd6, 32'h80000000,   32'hFFFFFFFF, 32'd0,        0};
    vt[12] = '{3'd6, 32'd5,          32'd0,        32'd5,        0};
    vt[13] = '{3'd5, 32'd5,          32'd0,        32'hFFFFFFFF, 0};
    vt[14] = '{3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'd1,        33};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = '0;
    bus.rs1 = '0; bus.rs2 = '0; bus.tag_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_tag_out", 32'(bus.tag_out), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 15; i++) begin
      t0 = (i == 0) ? 5'd17 : 5'(i + 1);
      run_op(vt[i].op, vt[i].a, vt[i].b, t0, res, tg, lat);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_tag", i), 32'(tg), 32'(t0));
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
      release_result();
    end

    // Randomized ops against the reference model
    for (int i = 0; i < 150; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      t0 = 5'($urandom);
      run_op(op, a, b, t0, res, tg, lat);
      chk($sformatf("rnd%0d_op%0d_%h_%h_result", i, op, a, b), res, model(op, a, b));
      chk($sformatf("rnd%0d_tag", i), 32'(tg), 32'(t0));
      chk($sformatf("rnd%0d_latency", i), lat, model_lat(op, a, b));
      release_result();
    end

    // Backpressure: DONE held for 10 cycles, then handoff without back-to-back accept
    run_op(3'd5, 32'd100, 32'd7, 5'd9, r0, t0, lat);
    chk("bp_result", r0, 32'd14);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.result !== r0 || bus.tag_out !== t0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    chk("bp_stable_cycles_bad", bad, 0);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.rs1 = 32'd3; bus.rs2 = 32'd4; bus.tag_in = 5'd2;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("bp_handoff_out_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_handoff_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_handoff_busy", 32'(busy), 32'd0);
    run_op(3'd0, 32'd3, 32'd4, 5'd2, res, tg, lat);
    chk("bp_next_result", res, 32'd12);
    chk("bp_next_tag", 32'(tg), 32'd2);
    release_result();

    // Flush at cycle 10 of CALC, with a competing request that must be ignored
    bus.op = 3'd0; bus.rs1 = 32'd1234; bus.rs2 = 32'd5678; bus.tag_in = 5'd3; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("flush_no_result_cycles", bad, 0);
    run_op(3'd4, 32'd100, 32'd7, 5'd21, res, tg, lat);
    chk("flush_recover_result", res, 32'd14);
    chk("flush_recover_tag", 32'(tg), 32'd21);
    release_result();

    // Async reset pulse mid-CALC
    bus.op = 3'd6; bus.rs1 = 32'hFFFFFF00; bus.rs2 = 32'd7; bus.tag_in = 5'd6; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_tag_out", 32'(bus.tag_out), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("arst_no_result_cycles", bad, 0);
    run_op(3'd6, 32'hFFFFFF00, 32'd7, 5'd6, res, tg, lat);
    chk("arst_recover_result", res, model(3'd6, 32'hFFFFFF00, 32'd7));
    chk("arst_recover_latency", lat, NORMAL_LAT);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
